// File: rtl/pcie_tag_pkg.sv
// pcie_tag_pkg: shared constants, per-tag state record and popcount helper
// for the PCIe non-posted tag pool.
//   DCNT_W_DFLT      default dword counter width
//   TIMEOUT_CYC_DFLT default tag age limit (cycles)
//   MAX_TAGS         largest supported pool size
//   DCNT_MAX_W       storage width of the remaining-dword field
//   tag_state_t      {busy, rem} per tag
//   popcount()       ones count over a MAX_TAGS-wide vector
package pcie_tag_pkg;

  localparam int unsigned DCNT_W_DFLT      = 16;
  localparam int unsigned TIMEOUT_CYC_DFLT = 65535;
  localparam int unsigned MAX_TAGS         = 256;
  localparam int unsigned MAX_CNT_W        = $clog2(MAX_TAGS) + 1;
  // Remaining-dword storage is sized for the widest supported DCNT_W;
  // narrower builds leave the upper bits constant zero.
  localparam int unsigned DCNT_MAX_W       = 32;

  typedef struct packed {
    logic                  busy;
    logic [DCNT_MAX_W-1:0] rem;
  } tag_state_t;

  function automatic logic [MAX_CNT_W-1:0] popcount(input logic [MAX_TAGS-1:0] v);
    logic [MAX_CNT_W-1:0] n;
    n = '0;
    for (int unsigned i = 0; i < MAX_TAGS; i++) begin
      n = n + MAX_CNT_W'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/pcie_tag_rr_arb.sv
// pcie_tag_rr_arb: rotating-priority find-first-set, purely combinational.
//   mask_i    candidate tags
//   start_i   highest-priority index; search runs upward and wraps
//   idx_c_o   first set index at or after start_i (0 when none)
//   found_c_o any bit of mask_i set
module pcie_tag_rr_arb #(
  parameter int unsigned NUM_TAGS = 32,
  parameter int unsigned TAG_W    = $clog2(NUM_TAGS)
) (
  input  logic [NUM_TAGS-1:0] mask_i,
  input  logic [TAG_W-1:0]    start_i,
  output logic [TAG_W-1:0]    idx_c_o,
  output logic                found_c_o
);

  logic [TAG_W-1:0] idx_hi_c;
  logic [TAG_W-1:0] idx_lo_c;
  logic             found_hi_c;
  logic             found_lo_c;

  // Split candidates into those at/above start and those below it; the
  // descending scan leaves the lowest index of each half in place.
  always_comb begin
    idx_hi_c   = '0;
    idx_lo_c   = '0;
    found_hi_c = 1'b0;
    found_lo_c = 1'b0;
    for (int k = int'(NUM_TAGS) - 1; k >= 0; k--) begin
      if (mask_i[k]) begin
        if (TAG_W'(k) >= start_i) begin
          found_hi_c = 1'b1;
          idx_hi_c   = TAG_W'(k);
        end else begin
          found_lo_c = 1'b1;
          idx_lo_c   = TAG_W'(k);
        end
      end
    end
    found_c_o = found_hi_c | found_lo_c;
    idx_c_o   = found_hi_c ? idx_hi_c : idx_lo_c;
  end

endmodule

// File: rtl/pcie_tag_pool.sv
// pcie_tag_pool: PCIe non-posted request tag allocator with per-tag
// outstanding-dword tracking and round-robin tag offer.
//   iCLK, iRST_n        clock, async active-low reset
//   oTAG_OUT, oVALID    registered offer of a free tag
//   iGET, iTAG_DCNT     take the offered tag with expected dword count
//   iSET_FREE, iTAG_IN, iSET_TAG_DCNT  completion data for a tag
//   oFREE_CNT           registered count of free tags
//   oERR_UNEXP          one-cycle protocol error pulse
//   oTIMEOUT, oTIMEOUT_TAG  reclaim pulse and tag
// Optional macro TAG_TIMEOUT_EN enables per-tag age counters that reclaim
// stale tags; without it oTIMEOUT/oTIMEOUT_TAG are tied to 0.
module pcie_tag_pool
  import pcie_tag_pkg::*;
#(
  parameter int unsigned NUM_TAGS    = 32,
  parameter int unsigned TAG_W       = $clog2(NUM_TAGS),
  parameter int unsigned DCNT_W      = DCNT_W_DFLT,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DFLT
) (
  input  logic              iCLK,
  input  logic              iRST_n,
  output logic [TAG_W-1:0]  oTAG_OUT,
  output logic              oVALID,
  input  logic              iGET,
  input  logic [DCNT_W-1:0] iTAG_DCNT,
  input  logic              iSET_FREE,
  input  logic [TAG_W-1:0]  iTAG_IN,
  input  logic [DCNT_W-1:0] iSET_TAG_DCNT,
  output logic [TAG_W:0]    oFREE_CNT,
  output logic              oERR_UNEXP,
  output logic              oTIMEOUT,
  output logic [TAG_W-1:0]  oTIMEOUT_TAG
);

  localparam int unsigned CNT_W = TAG_W + 1;

  if (NUM_TAGS < 2 || NUM_TAGS > MAX_TAGS || DCNT_W == 0 ||
      DCNT_W > DCNT_MAX_W || TIMEOUT_CYC == 0) begin : g_param_chk
    $error("pcie_tag_pool: parameter out of range");
  end

  // Registered state
  tag_state_t       st_q [NUM_TAGS];
  tag_state_t       st_d [NUM_TAGS];
  logic [TAG_W-1:0] ptr_q;
  logic [TAG_W-1:0] ptr_d;
  logic [TAG_W-1:0] tag_out_q;
  logic             valid_q;
  logic [CNT_W-1:0] free_cnt_q;
  logic [CNT_W-1:0] free_cnt_d;
  logic             err_q;
  logic             err_d;

  // Combinational intermediates
  logic                  grant_c;
  logic                  grant_ok_c;
  logic                  grant_err_c;
  logic                  tag_in_ok_c;
  logic                  cpl_busy_c;
  logic                  cpl_blocked_c;
  logic                  cpl_ok_c;
  logic                  cpl_err_c;
  logic [DCNT_MAX_W-1:0] cpl_dcnt_c;
  logic [DCNT_MAX_W-1:0] cur_rem_c;
  logic                  to_fire_c;
  logic [TAG_W-1:0]      to_idx_c;
  logic [NUM_TAGS-1:0]   busy_vec_c;
  logic [NUM_TAGS-1:0]   busy_nxt_c;
  logic [NUM_TAGS-1:0]   free_nxt_c;
  logic [NUM_TAGS-1:0]   grant_mask_c;
  logic [NUM_TAGS-1:0]   offer_mask_c;
  logic [TAG_W-1:0]      start_c;
  logic [TAG_W-1:0]      offer_idx_c;
  logic                  offer_found_c;

  // Grant/completion decode and per-tag next state
  always_comb begin
    grant_c     = iGET & valid_q;
    grant_ok_c  = grant_c & (iTAG_DCNT != '0);
    grant_err_c = grant_c & (iTAG_DCNT == '0);

    tag_in_ok_c = (iTAG_IN <= TAG_W'(NUM_TAGS - 1));
    cur_rem_c   = st_q[iTAG_IN].rem;
    cpl_dcnt_c  = DCNT_MAX_W'(iSET_TAG_DCNT);
    cpl_busy_c  = iSET_FREE & tag_in_ok_c & st_q[iTAG_IN].busy;
    // A completion racing a grant or a timeout on its tag loses and is
    // treated as a completion to an idle tag.
    cpl_blocked_c = (grant_ok_c & (iTAG_IN == tag_out_q)) |
                    (to_fire_c  & (iTAG_IN == to_idx_c));
    cpl_ok_c    = cpl_busy_c & ~cpl_blocked_c;
    cpl_err_c   = (iSET_FREE & ~cpl_ok_c) | (cpl_ok_c & (cpl_dcnt_c > cur_rem_c));
    err_d       = grant_err_c | cpl_err_c;

    st_d = st_q;
    if (cpl_ok_c) begin
      if (cpl_dcnt_c >= cur_rem_c) begin
        st_d[iTAG_IN] = '0;
      end else begin
        st_d[iTAG_IN].rem = cur_rem_c - cpl_dcnt_c;
      end
    end
    if (grant_ok_c) begin
      st_d[tag_out_q].busy = 1'b1;
      st_d[tag_out_q].rem  = DCNT_MAX_W'(iTAG_DCNT);
    end
    if (to_fire_c) begin
      st_d[to_idx_c] = '0;
    end

    ptr_d = grant_ok_c ? tag_out_q : ptr_q;
  end

  // Busy vectors, free count and offer search inputs
  always_comb begin
    for (int unsigned t = 0; t < NUM_TAGS; t++) begin
      busy_vec_c[t] = st_q[t].busy;
      busy_nxt_c[t] = st_d[t].busy;
    end
    free_nxt_c   = ~busy_nxt_c;
    free_cnt_d   = CNT_W'(popcount(MAX_TAGS'(free_nxt_c)));
    // Offer uses pre-update busy so freed tags wait a cycle; the tag taken
    // this cycle is masked explicitly.
    grant_mask_c = grant_ok_c ? (NUM_TAGS'(1) << tag_out_q) : '0;
    offer_mask_c = ~busy_vec_c & ~grant_mask_c;
    start_c      = (ptr_d == TAG_W'(NUM_TAGS - 1)) ? '0 : ptr_d + TAG_W'(1);
  end

  pcie_tag_rr_arb #(
    .NUM_TAGS (NUM_TAGS),
    .TAG_W    (TAG_W)
  ) u_arb (
    .mask_i    (offer_mask_c),
    .start_i   (start_c),
    .idx_c_o   (offer_idx_c),
    .found_c_o (offer_found_c)
  );

  // Pool state and registered outputs
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      for (int unsigned t = 0; t < NUM_TAGS; t++) begin
        st_q[t] <= '0;
      end
      ptr_q      <= TAG_W'(NUM_TAGS - 1);
      tag_out_q  <= '0;
      valid_q    <= 1'b0;
      free_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      for (int unsigned t = 0; t < NUM_TAGS; t++) begin
        st_q[t] <= st_d[t];
      end
      ptr_q      <= ptr_d;
      tag_out_q  <= offer_idx_c;
      valid_q    <= offer_found_c;
      free_cnt_q <= free_cnt_d;
      err_q      <= err_d;
    end
  end

  assign oTAG_OUT   = tag_out_q;
  assign oVALID     = valid_q;
  assign oFREE_CNT  = free_cnt_q;
  assign oERR_UNEXP = err_q;

`ifdef TAG_TIMEOUT_EN
  localparam int unsigned     AGE_W   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [AGE_W-1:0] AGE_LIM = AGE_W'(TIMEOUT_CYC);

  logic [AGE_W-1:0] age_q [NUM_TAGS];
  logic [AGE_W-1:0] age_d [NUM_TAGS];
  logic             to_q;
  logic [TAG_W-1:0] to_tag_q;

  // Lowest-index expired tag is reclaimed; others wait at the limit
  always_comb begin
    to_fire_c = 1'b0;
    to_idx_c  = '0;
    for (int t = int'(NUM_TAGS) - 1; t >= 0; t--) begin
      if (st_q[t].busy && (age_q[t] == AGE_LIM)) begin
        to_fire_c = 1'b1;
        to_idx_c  = TAG_W'(t);
      end
    end
  end

  // Age counters: restart on grant or accepted completion, saturate at limit
  always_comb begin
    for (int unsigned t = 0; t < NUM_TAGS; t++) begin
      age_d[t] = age_q[t];
      if (!st_d[t].busy) begin
        age_d[t] = '0;
      end else if ((grant_ok_c && (tag_out_q == TAG_W'(t))) ||
                   (cpl_ok_c && (iTAG_IN == TAG_W'(t)))) begin
        age_d[t] = '0;
      end else if (age_q[t] != AGE_LIM) begin
        age_d[t] = age_q[t] + AGE_W'(1);
      end
    end
  end

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      for (int unsigned t = 0; t < NUM_TAGS; t++) begin
        age_q[t] <= '0;
      end
      to_q     <= 1'b0;
      to_tag_q <= '0;
    end else begin
      for (int unsigned t = 0; t < NUM_TAGS; t++) begin
        age_q[t] <= age_d[t];
      end
      to_q     <= to_fire_c;
      to_tag_q <= to_idx_c;
    end
  end

  assign oTIMEOUT     = to_q;
  assign oTIMEOUT_TAG = to_tag_q;
`else
  assign to_fire_c    = 1'b0;
  assign to_idx_c     = '0;
  assign oTIMEOUT     = 1'b0;
  assign oTIMEOUT_TAG = '0;
`endif

endmodule

// File: tb/tb_pcie_tag_pool.sv
// tb_pcie_tag_pool: directed self-checking bench for pcie_tag_pool
// (NUM_TAGS=32, DCNT_W=16, TIMEOUT_CYC=100). The reclaim scenario is
// exercised when TAG_TIMEOUT_EN is defined.
module tb_pcie_tag_pool;

  localparam int unsigned NT = 32;
  localparam int unsigned TW = 5;
  localparam int unsigned DW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [TW-1:0] tag_out;
  logic          valid;
  logic          get;
  logic [DW-1:0] tag_dcnt;
  logic          set_free;
  logic [TW-1:0] tag_in;
  logic [DW-1:0] set_dcnt;
  logic [TW:0]   free_cnt;
  logic          err;
  logic          to;
  logic [TW-1:0] to_tag;

  int n_checks  = 0;
  int n_err     = 0;
  int to_pulses = 0;
  int pulses;
  int t1_cyc;
  int t2_cyc;
  logic [TW-1:0] t1_tag;
  logic [TW-1:0] t2_tag;

  always #5 clk = ~clk;

  pcie_tag_pool #(
    .NUM_TAGS    (NT),
    .DCNT_W      (DW),
    .TIMEOUT_CYC (100)
  ) dut (
    .iCLK          (clk),
    .iRST_n        (rst_n),
    .oTAG_OUT      (tag_out),
    .oVALID        (valid),
    .iGET          (get),
    .iTAG_DCNT     (tag_dcnt),
    .iSET_FREE     (set_free),
    .iTAG_IN       (tag_in),
    .iSET_TAG_DCNT (set_dcnt),
    .oFREE_CNT     (free_cnt),
    .oERR_UNEXP    (err),
    .oTIMEOUT      (to),
    .oTIMEOUT_TAG  (to_tag)
  );

  always @(posedge clk) begin
    if (to === 1'b1) to_pulses++;
  end

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", name, obs, exp);
    end
  endtask

  task automatic drive(input logic g, input logic [DW-1:0] gd, input logic sf,
                       input logic [TW-1:0] st, input logic [DW-1:0] sd);
    get      = g;
    tag_dcnt = gd;
    set_free = sf;
    tag_in   = st;
    set_dcnt = sd;
  endtask

  task automatic idle();
    drive(1'b0, '0, 1'b0, '0, '0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    repeat (3) tick();
    chk("rst_valid", 32'(valid), 0);
    chk("rst_tag", 32'(tag_out), 0);
    chk("rst_free", 32'(free_cnt), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_to", 32'(to), 0);
    chk("rst_to_tag", 32'(to_tag), 0);

    rst_n = 1'b1;
    tick();
    chk("post_rst_valid", 32'(valid), 1);
    chk("post_rst_tag", 32'(tag_out), 0);
    chk("post_rst_free", 32'(free_cnt), 32);

    // Exhaust the pool with back-to-back grants
    drive(1'b1, 16'd4, 1'b0, '0, '0);
    for (int i = 0; i < 32; i++) begin
      chk("exh_tag", 32'(tag_out), 32'(i));
      chk("exh_valid", 32'(valid), 1);
      chk("exh_free", 32'(free_cnt), 32'(32 - i));
      tick();
    end
    idle();
    chk("exh_valid_end", 32'(valid), 0);
    chk("exh_free_end", 32'(free_cnt), 0);
    chk("exh_err", 32'(err), 0);

    // Overrun tag 3 (rem 4, completion 6): freed with error
    drive(1'b0, '0, 1'b1, 5'd3, 16'd6);
    tick();
    idle();
    chk("ovr_err", 32'(err), 1);
    chk("ovr_free", 32'(free_cnt), 1);
    chk("ovr_valid_lat", 32'(valid), 0);
    tick();
    chk("ovr_err_clr", 32'(err), 0);
    chk("ovr_valid", 32'(valid), 1);
    chk("ovr_offer", 32'(tag_out), 3);

    // Completion to idle tag 3
    drive(1'b0, '0, 1'b1, 5'd3, 16'd1);
    tick();
    idle();
    chk("idle_err", 32'(err), 1);
    chk("idle_free", 32'(free_cnt), 1);
    chk("idle_offer", 32'(tag_out), 3);
    tick();
    chk("idle_err_clr", 32'(err), 0);

    // Grant with zero dword count
    drive(1'b1, 16'd0, 1'b0, '0, '0);
    tick();
    idle();
    chk("zero_err", 32'(err), 1);
    chk("zero_free", 32'(free_cnt), 1);
    chk("zero_valid", 32'(valid), 1);
    chk("zero_offer", 32'(tag_out), 3);
    tick();
    chk("zero_err_clr", 32'(err), 0);

    // Exact completion frees tag 10
    drive(1'b0, '0, 1'b1, 5'd10, 16'd4);
    tick();
    idle();
    chk("exact_err", 32'(err), 0);
    chk("exact_free", 32'(free_cnt), 2);
    chk("exact_offer", 32'(tag_out), 3);

    // Grant tag 3 while completion frees tag 9
    drive(1'b1, 16'd16, 1'b1, 5'd9, 16'd4);
    tick();
    idle();
    chk("conc_err", 32'(err), 0);
    chk("conc_free", 32'(free_cnt), 2);
    chk("conc_offer", 32'(tag_out), 10);
    tick();
    chk("conc_offer_9", 32'(tag_out), 9);
    chk("conc_free2", 32'(free_cnt), 2);

    // Partial completions on tag 3 (rem 16): 8 then 8
    drive(1'b0, '0, 1'b1, 5'd3, 16'd8);
    tick();
    idle();
    chk("part1_err", 32'(err), 0);
    chk("part1_free", 32'(free_cnt), 2);
    drive(1'b0, '0, 1'b1, 5'd3, 16'd8);
    tick();
    idle();
    chk("part2_err", 32'(err), 0);
    chk("part2_free", 32'(free_cnt), 3);
    tick();
    chk("part_no_reoffer", 32'(tag_out), 9);

    // Two grants move the pointer past the end; tag 3 comes back on wrap
    drive(1'b1, 16'd1, 1'b0, '0, '0);
    tick();
    chk("g9_offer", 32'(tag_out), 10);
    chk("g9_free", 32'(free_cnt), 2);
    tick();
    idle();
    chk("wrap_offer", 32'(tag_out), 3);
    chk("wrap_free", 32'(free_cnt), 1);

    // Completion on the tag being granted: grant wins, error pulses
    drive(1'b1, 16'd2, 1'b1, 5'd3, 16'd2);
    tick();
    idle();
    chk("gc_err", 32'(err), 1);
    chk("gc_free", 32'(free_cnt), 0);
    chk("gc_valid", 32'(valid), 0);
    tick();
    chk("gc_err_clr", 32'(err), 0);

    // Free tag 9 (rem 1), then grant error and completion error together
    drive(1'b0, '0, 1'b1, 5'd9, 16'd1);
    tick();
    idle();
    chk("f9_err", 32'(err), 0);
    chk("f9_free", 32'(free_cnt), 1);
    tick();
    chk("f9_valid", 32'(valid), 1);
    chk("f9_offer", 32'(tag_out), 9);
    drive(1'b1, 16'd0, 1'b1, 5'd9, 16'd1);
    tick();
    idle();
    chk("dual_err", 32'(err), 1);
    chk("dual_free", 32'(free_cnt), 1);
    tick();
    chk("dual_single_pulse", 32'(err), 0);

    // Reset while tags are outstanding
    rst_n = 1'b0;
    #1;
    chk("mrst_valid", 32'(valid), 0);
    chk("mrst_free", 32'(free_cnt), 0);
    chk("mrst_err", 32'(err), 0);
    chk("mrst_tag", 32'(tag_out), 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("mrst_rel_valid", 32'(valid), 1);
    chk("mrst_rel_tag", 32'(tag_out), 0);
    chk("mrst_rel_free", 32'(free_cnt), 32);
    chk("mrst_rel_err", 32'(err), 0);

`ifdef TAG_TIMEOUT_EN
    // Grant 0..4; a partial completion on tag 1 aligns its age with tag 4
    for (int i = 0; i < 5; i++) begin
      if (i == 4) drive(1'b1, 16'd8, 1'b1, 5'd1, 16'd1);
      else        drive(1'b1, 16'd8, 1'b0, '0, '0);
      tick();
    end
    drive(1'b0, '0, 1'b1, 5'd0, 16'd8);
    tick();
    drive(1'b0, '0, 1'b1, 5'd2, 16'd8);
    tick();
    drive(1'b0, '0, 1'b1, 5'd3, 16'd8);
    tick();
    idle();
    chk("to_pre_free", 32'(free_cnt), 30);
    pulses = 0;
    t1_cyc = 0;
    t2_cyc = 0;
    t1_tag = '0;
    t2_tag = '0;
    for (int c = 0; c < 300 && pulses < 2; c++) begin
      tick();
      if (to === 1'b1) begin
        if (pulses == 0) begin
          t1_tag = to_tag;
          t1_cyc = c;
        end else begin
          t2_tag = to_tag;
          t2_cyc = c;
        end
        pulses++;
      end
    end
    chk("to_pulses", 32'(pulses), 2);
    chk("to_first_tag", 32'(t1_tag), 1);
    chk("to_second_tag", 32'(t2_tag), 4);
    chk("to_gap", 32'(t2_cyc - t1_cyc), 1);
    chk("to_free", 32'(free_cnt), 32);
    chk("to_err", 32'(err), 0);
    tick();
    chk("to_clr", 32'(to), 0);
`else
    chk("no_timeout_pulse", 32'(to_pulses), 0);
    chk("no_timeout_tag", 32'(to_tag), 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
